// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving the en/sel of a 4-way demux, with hold timeout and a GAP cycle.
// Optional build macro DEMUX_SCHED_PRIO_EN: channel 0 wins every IDLE arbitration it requests.
module demux_rr_sched #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic [3:0] done_i,
  output logic       en_o,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [1:0] state_o
);

  // Handshake: req_i[k] is a level request held while channel k wants the demux;
  // gnt_o[k] is the acknowledge and stays high until done_i[k] pulses, req_i[k]
  // drops, or the hold limit is reached. done_i for non-granted channels is ignored.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;
  logic       rel_norm;
  logic       rel_to;

  // First requesting channel at or after ptr_q, wrapping mod 4.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef DEMUX_SCHED_PRIO_EN
    if (req_i[0]) win = 2'd0;
`endif
  end

  // Done/request-drop outranks the timeout when both hit in the same cycle.
  assign rel_norm = done_i[sel_q] || !req_i[sel_q];
  assign rel_to   = !rel_norm && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    en_d      = en_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i != 4'd0) begin
          sel_d   = win;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_norm || rel_to) begin
          en_d      = 1'b0;
          ptr_d     = sel_q + 2'd1;
          timeout_d = rel_to;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign en_o      = en_q;
  assign sel_o     = sel_q;
  assign gnt_o     = en_q ? (4'b0001 << sel_q) : 4'b0000;
  assign busy_o    = (state_q != ST_IDLE);
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Scoreboard bench for demux_rr_sched: a behavioural model predicts every output cycle.
module tb_demux_rr_sched;

  localparam int HOLD_MAX = 8;
  localparam int W = 9;  // {en, sel[1:0], gnt[3:0], busy, timeout}

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] done_i;
  logic       en_o;
  logic [1:0] sel_o;
  logic [3:0] gnt_o;
  logic       busy_o;
  logic       timeout_o;
  logic [1:0] state_o;

  demux_rr_sched #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .done_i    (done_i),
    .en_o      (en_o),
    .sel_o     (sel_o),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .state_o   (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // phase: 0 = nobody owns the demux, 1 = owner holds it, 2 = mandatory dead cycle
  int m_phase;
  int m_ptr;
  int m_owner;
  int m_held;
  bit m_to;

  logic [W-1:0] exp_q[$];
  int checks;
  int fails;
  int grants_seen[4];

  function automatic int pick(input logic [3:0] req, input int ptr);
    int w;
    w = -1;
`ifdef DEMUX_SCHED_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && req[(ptr + i) % 4]) w = (ptr + i) % 4;
    end
    return w;
  endfunction

  function automatic logic [W-1:0] pack_exp();
    logic [3:0] g;
    logic       en;
    en = (m_phase == 1);
    g  = en ? 4'(1 << m_owner) : 4'd0;
    return {en, 2'(m_owner), g, (m_phase != 0), m_to};
  endfunction

  // Advance the model across one rising edge with the inputs currently driven.
  task automatic model_edge();
    m_to = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_held = 0;
    end else if (m_phase == 0) begin
      if (req_i != 4'd0) begin
        m_owner = pick(req_i, m_ptr);
        m_held  = 1;
        m_phase = 1;
        grants_seen[m_owner]++;
      end
    end else if (m_phase == 1) begin
      if (done_i[m_owner] || !req_i[m_owner] || m_held >= HOLD_MAX) begin
        m_to    = !(done_i[m_owner] || !req_i[m_owner]);
        m_ptr   = (m_owner + 1) % 4;
        m_phase = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] done);
    rst_n  = rst;
    req_i  = req;
    done_i = done;
    model_edge();
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {en_o, sel_o, gnt_o, busy_o, timeout_o};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL outputs t=%0t {en,sel,gnt,busy,to} actual=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                 $time, act_v[8], act_v[7:6], act_v[5:2], act_v[1], act_v[0],
                 exp_v[8], exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    logic [3:0] d;
    checks = 0;
    fails  = 0;
    m_phase = 0; m_ptr = 0; m_owner = 0; m_held = 0; m_to = 1'b0;
    for (int k = 0; k < 4; k++) grants_seen[k] = 0;
    rst_n = 1'b0; req_i = 4'd0; done_i = 4'd0;
    #1;

    // Reset with all requests high, then rotation with done pulsed every cycle.
    step(1'b0, 4'hF, 4'h0);
    step(1'b0, 4'hF, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 4'hF);

    // Single requester never releases: forced timeout, then re-grant.
    for (int i = 0; i < 25; i++) step(1'b1, 4'b0100, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0);

    // done lands on the final hold cycle: must count as a normal release.
    for (int i = 0; i < 14; i++) begin
      d = (m_phase == 1 && m_held == HOLD_MAX) ? 4'b0010 : 4'h0;
      step(1'b1, 4'b0010, d);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0);

    // Reset while channel 3 owns the demux, then ptr must be back at 0.
    for (int i = 0; i < 12 && !(m_phase == 1 && m_owner == 3 && m_held >= 3); i++)
      step(1'b1, 4'b1000, 4'h0);
    step(1'b0, 4'b1000, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1001, 4'b0001);

    // Priority build vs pure round-robin: ptr=1 with req 0011.
    for (int i = 0; i < 6 && !(m_phase == 0 && m_ptr == 1); i++) step(1'b1, 4'b0001, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0);

    // Randomized traffic with sparse done pulses and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(($urandom_range(0, 199) != 0), r, d);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
